// File: rtl/elevator_controller.sv
// Six-floor elevator car controller.
// Latches car and hall calls, sweeps up/down collectively, and steps the car
// one floor per FLOOR_TICKS cycles, holding the door for DOOR_TICKS cycles.
// onow is the binary floor (1..6); ostate is the one-hot FSM state register.
module elevator_controller #(
   parameter int FLOOR_TICKS = 8,
   parameter int DOOR_TICKS  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] input_in,
   input  logic [9:0] input_out,
   output logic [2:0] onow,
   output logic [3:0] ostate
);

   // State encodings double as the one-hot display code, so ostate is the register itself.
   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_UP   = 4'b0010,
      S_DOWN = 4'b0100,
      S_OPEN = 4'b1000
   } state_t;

   localparam logic [15:0] FLOOR_LAST = 16'(FLOOR_TICKS - 1);
   localparam logic [15:0] DOOR_LAST  = 16'(DOOR_TICKS - 1);

   state_t      state;
   logic [5:0]  car;        // bit i = floor i+1
   logic [4:0]  up;         // bit i = UP call at floor i+1
   logic [4:0]  dn;         // bit i = DOWN call at floor i+2
   logic        dir_up;     // last direction of motion
   logic [15:0] travel_cnt;
   logic [15:0] door_cnt;

   // Floor-aligned views: bit i of each vector refers to floor i+1.
   logic [5:0] up6, dn6, req;
   logic [2:0] idx, nidx;
   logic [5:0] cur_oh, nxt_oh;
   logic       here, above, below;
   logic       stop_up, stop_dn;
   logic [5:0] clr_car, clr_up6, clr_dn6;

   assign up6 = {1'b0, up};
   assign dn6 = {dn, 1'b0};
   assign req = car | up6 | dn6;
   assign ostate = state;

   function automatic logic any_above(input logic [5:0] r, input logic [2:0] i);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 6; k++)
         if (k > int'(i) && r[k]) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic any_below(input logic [5:0] r, input logic [2:0] i);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 6; k++)
         if (k < int'(i) && r[k]) hit = 1'b1;
      return hit;
   endfunction

   // Request summary around the current floor and stop test for the floor being entered.
   always_comb begin
      idx     = onow - 3'd1;
      nidx    = (state == S_DOWN) ? idx - 3'd1 : idx + 3'd1;
      cur_oh  = 6'b000001 << idx;
      nxt_oh  = 6'b000001 << nidx;
      here    = |(req & cur_oh);
      above   = any_above(req, idx);
      below   = any_below(req, idx);
      stop_up = (|(car & nxt_oh)) || (|(up6 & nxt_oh)) || !any_above(req, nidx) || (nidx == 3'd5);
      stop_dn = (|(car & nxt_oh)) || (|(dn6 & nxt_oh)) || !any_below(req, nidx) || (nidx == 3'd0);
   end

   // Calls served at the current floor; clearing has priority over a new press.
   always_comb begin
      clr_car = 6'b0;
      clr_up6 = 6'b0;
      clr_dn6 = 6'b0;
      if (state == S_OPEN) begin
         clr_car = cur_oh;
         if (dir_up) begin
            clr_up6 = cur_oh;
            if (!above) clr_dn6 = cur_oh;
         end else begin
            clr_dn6 = cur_oh;
            if (!below) clr_up6 = cur_oh;
         end
      end else if (state == S_IDLE && here) begin
         clr_car = cur_oh;
         clr_up6 = cur_oh;
         clr_dn6 = cur_oh;
      end
   end

   // Pending-call registers, floor position, timers and the sweep FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         onow       <= 3'd1;
         car        <= 6'b0;
         up         <= 5'b0;
         dn         <= 5'b0;
         dir_up     <= 1'b1;
         travel_cnt <= 16'd0;
         door_cnt   <= 16'd0;
      end else begin
         car <= (car | input_in)       & ~clr_car;
         up  <= (up  | input_out[4:0]) & ~clr_up6[4:0];
         dn  <= (dn  | input_out[9:5]) & ~clr_dn6[5:1];
         case (state)
            S_IDLE: begin
               travel_cnt <= 16'd0;
               door_cnt   <= 16'd0;
               if (here) begin
                  state <= S_OPEN;
               end else if (above) begin
                  state  <= S_UP;
                  dir_up <= 1'b1;
               end else if (below) begin
                  state  <= S_DOWN;
                  dir_up <= 1'b0;
               end
            end
            S_UP: begin
               if (onow == 3'd6) begin
                  state    <= S_OPEN;
                  door_cnt <= 16'd0;
               end else if (travel_cnt == FLOOR_LAST) begin
                  onow       <= onow + 3'd1;
                  travel_cnt <= 16'd0;
                  if (stop_up) begin
                     state    <= S_OPEN;
                     door_cnt <= 16'd0;
                  end
               end else begin
                  travel_cnt <= travel_cnt + 16'd1;
               end
            end
            S_DOWN: begin
               if (onow == 3'd1) begin
                  state    <= S_OPEN;
                  door_cnt <= 16'd0;
               end else if (travel_cnt == FLOOR_LAST) begin
                  onow       <= onow - 3'd1;
                  travel_cnt <= 16'd0;
                  if (stop_dn) begin
                     state    <= S_OPEN;
                     door_cnt <= 16'd0;
                  end
               end else begin
                  travel_cnt <= travel_cnt + 16'd1;
               end
            end
            S_OPEN: begin
               travel_cnt <= 16'd0;
               if (door_cnt == DOOR_LAST) begin
                  door_cnt <= 16'd0;
                  if (dir_up) begin
                     if (above) begin
                        state <= S_UP;
                     end else if (below) begin
                        state  <= S_DOWN;
                        dir_up <= 1'b0;
                     end else begin
                        state <= S_IDLE;
                     end
                  end else begin
                     if (below) begin
                        state <= S_DOWN;
                     end else if (above) begin
                        state  <= S_UP;
                        dir_up <= 1'b1;
                     end else begin
                        state <= S_IDLE;
                     end
                  end
               end else begin
                  door_cnt <= door_cnt + 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller: expected floor/state pairs are queued
// when a step is issued and compared when the step's cycle count elapses.
module tb_elevator_controller;

   localparam logic [3:0] IDLE = 4'b0001;
   localparam logic [3:0] UP   = 4'b0010;
   localparam logic [3:0] DOWN = 4'b0100;
   localparam logic [3:0] OPEN = 4'b1000;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] input_in;
   logic [9:0] input_out;
   logic [2:0] onow;
   logic [3:0] ostate;

   int total = 0;
   int bad   = 0;
   logic [6:0] exp_q[$];

   // Clock
   always #5 clk = ~clk;

   elevator_controller #(.FLOOR_TICKS(8), .DOOR_TICKS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .input_in  (input_in),
      .input_out (input_out),
      .onow      (onow),
      .ostate    (ostate)
   );

   // Queue the expected {floor, state}, advance n falling edges, then compare.
   task automatic expect_after(input int n, input logic [2:0] f, input logic [3:0] s,
                               input string tag);
      logic [6:0] exp_v;
      logic [6:0] obs_v;
      exp_q.push_back({f, s});
      repeat (n) @(negedge clk);
      exp_v = exp_q.pop_front();
      obs_v = {onow, ostate};
      total++;
      assert (obs_v === exp_v) else begin
         bad++;
         $error("FAIL %s: got onow=%0d ostate=%b, want onow=%0d ostate=%b",
                tag, obs_v[6:4], obs_v[3:0], exp_v[6:4], exp_v[3:0]);
      end
   endtask

   initial begin
      // Reset with the floor-6 car button already held
      rst       = 1'b1;
      input_in  = 6'b100000;
      input_out = 10'b0;
      repeat (3) @(negedge clk);
      expect_after(0, 3'd1, IDLE, "reset");
      rst = 1'b0;

      // Travel 1 -> 6
      expect_after(1, 3'd1, IDLE, "latch_cycle");
      expect_after(1, 3'd1, UP,   "start_up");
      expect_after(7, 3'd1, UP,   "travel_hold");
      expect_after(1, 3'd2, UP,   "floor2");
      expect_after(8, 3'd3, UP,   "floor3");
      expect_after(8, 3'd4, UP,   "floor4");
      expect_after(8, 3'd5, UP,   "floor5");
      expect_after(8, 3'd6, OPEN, "arrive6");
      expect_after(7, 3'd6, OPEN, "door6_last");

      // Held button reopens the door through IDLE
      expect_after(1, 3'd6, IDLE, "door6_close");
      expect_after(1, 3'd6, IDLE, "relatch6");
      expect_after(1, 3'd6, OPEN, "reopen6");
      expect_after(7, 3'd6, OPEN, "reopen6_last");
      expect_after(1, 3'd6, IDLE, "reclose6");
      input_in = 6'b0;
      expect_after(3, 3'd6, IDLE, "idle6");

      // Down sweep: car 1, DOWN at 2 and 5
      input_in  = 6'b000001;
      input_out = 10'b0100100000;
      expect_after(1, 3'd6, IDLE, "t3_latch");
      input_in  = 6'b0;
      input_out = 10'b0;
      expect_after(1, 3'd6, DOWN, "t3_go_down");
      expect_after(8, 3'd5, OPEN, "stop5");
      expect_after(7, 3'd5, OPEN, "stop5_last");
      expect_after(1, 3'd5, DOWN, "leave5");
      expect_after(8, 3'd4, DOWN, "pass4");
      expect_after(8, 3'd3, DOWN, "pass3");
      expect_after(8, 3'd2, OPEN, "stop2");
      expect_after(7, 3'd2, OPEN, "stop2_last");
      expect_after(1, 3'd2, DOWN, "leave2");
      expect_after(8, 3'd1, OPEN, "stop1");
      expect_after(7, 3'd1, OPEN, "stop1_last");
      expect_after(1, 3'd1, IDLE, "idle1");
      expect_after(3, 3'd1, IDLE, "all_clear");

      // Up to 6, car call to 1, UP call at 3 pressed while descending
      input_in = 6'b100000;
      expect_after(1, 3'd1, IDLE, "t4_latch");
      input_in = 6'b0;
      expect_after(1, 3'd1, UP,   "t4_start");
      expect_after(40, 3'd6, OPEN, "t4_arrive6");
      input_in = 6'b000001;
      expect_after(1, 3'd6, OPEN, "t4_car1");
      input_in = 6'b0;
      expect_after(6, 3'd6, OPEN, "t4_door_last");
      expect_after(1, 3'd6, DOWN, "t4_leave6");
      expect_after(8, 3'd5, DOWN, "t4_pass5");
      input_out = 10'b0000000100;
      expect_after(1, 3'd5, DOWN, "t4_up3_press");
      input_out = 10'b0;
      expect_after(7, 3'd4, DOWN, "t4_pass4");
      expect_after(8, 3'd3, DOWN, "t4_skip3");
      expect_after(8, 3'd2, DOWN, "t4_pass2");
      expect_after(8, 3'd1, OPEN, "t4_stop1");
      expect_after(7, 3'd1, OPEN, "t4_stop1_last");
      expect_after(1, 3'd1, UP,   "t4_reverse");
      expect_after(8, 3'd2, UP,   "t4_pass2_up");
      expect_after(8, 3'd3, OPEN, "t4_stop3");
      expect_after(7, 3'd3, OPEN, "t4_stop3_last");
      expect_after(1, 3'd3, IDLE, "t4_idle3");

      // Go to 4, then a call at the current floor opens the door in place
      input_in = 6'b001000;
      expect_after(1, 3'd3, IDLE, "t5_latch");
      input_in = 6'b0;
      expect_after(1, 3'd3, UP,   "t5_start");
      expect_after(8, 3'd4, OPEN, "t5_arrive4");
      expect_after(7, 3'd4, OPEN, "t5_door_last");
      expect_after(1, 3'd4, IDLE, "t5_idle4");
      expect_after(2, 3'd4, IDLE, "t5_idle4_hold");
      input_in = 6'b001000;
      expect_after(1, 3'd4, IDLE, "here_latch");
      input_in = 6'b0;
      expect_after(1, 3'd4, OPEN, "here_open");
      expect_after(7, 3'd4, OPEN, "here_open_last");
      expect_after(1, 3'd4, IDLE, "here_close");
      expect_after(3, 3'd4, IDLE, "here_cleared");

      // Reset mid-travel with every button pressed during reset
      input_in = 6'b000001;
      expect_after(1, 3'd4, IDLE, "t6_latch");
      input_in = 6'b0;
      expect_after(1, 3'd4, DOWN, "t6_start");
      expect_after(4, 3'd4, DOWN, "t6_mid");
      rst       = 1'b1;
      input_in  = 6'b111111;
      input_out = 10'h3FF;
      expect_after(1, 3'd1, IDLE, "rst_mid");
      expect_after(1, 3'd1, IDLE, "rst_hold");
      rst       = 1'b0;
      input_in  = 6'b0;
      input_out = 10'b0;
      expect_after(5, 3'd1, IDLE, "no_pending");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
